// File: rtl/vga_framebuffer.sv
// Low-resolution framebuffer feeding the VGA timing generator: 1-cycle upscaled
// pixel read, single-pixel CPU write port with handshake, and a whole-buffer clear engine.
module vga_framebuffer #(
   parameter int FB_WIDTH    = 160,
   parameter int FB_HEIGHT   = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15
) (
   input  logic        clk,
   input  logic        res,
   input  logic [15:0] pix_x,
   input  logic [15:0] pix_y,
   output logic [11:0] color,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [15:0] wr_x,
   input  logic [15:0] wr_y,
   input  logic [11:0] wr_color,
   input  logic        clr_start,
   input  logic [11:0] clr_color,
   output logic        busy,
   output logic        oob_err
);

   localparam int                DEPTH  = FB_WIDTH * FB_HEIGHT;
   localparam logic [15:0]       FBW16  = 16'(FB_WIDTH);
   localparam logic [15:0]       FBH16  = 16'(FB_HEIGHT);
   localparam logic [ADDR_W-1:0] FBW_A  = ADDR_W'(FB_WIDTH);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   function automatic logic [ADDR_W-1:0] fb_addr(input logic [15:0] fx, input logic [15:0] fy);
      return ADDR_W'(fy) * FBW_A + ADDR_W'(fx);
   endfunction

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic [11:0]        clr_col_q, clr_col_d;
   logic               busy_q, busy_d;
   logic               oob_q, oob_d;
   logic               in_range_q, in_range_d;

   logic [11:0]        mem [0:DEPTH-1];
   logic [11:0]        rd_q;

   logic [15:0]        rd_fx, rd_fy;
   logic [ADDR_W-1:0]  rd_addr;
   logic               wr_in, wr_fire;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [11:0]        mem_wdata;

   // Read path is independent of the FSM; out-of-range reads park on address 0 and are masked.
   always_comb begin
      rd_fx      = pix_x >> SCALE_SHIFT;
      rd_fy      = pix_y >> SCALE_SHIFT;
      in_range_d = (rd_fx < FBW16) && (rd_fy < FBH16);
      rd_addr    = in_range_d ? fb_addr(rd_fx, rd_fy) : '0;
   end

   assign wr_ready = (state_q == IDLE) && res;
   assign wr_fire  = wr_valid && wr_ready;
   assign wr_in    = (wr_x < FBW16) && (wr_y < FBH16);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_col_d = clr_col_q;
      busy_d    = busy_q;
      oob_d     = oob_q;
      mem_we    = 1'b0;
      mem_waddr = fb_addr(wr_x, wr_y);
      mem_wdata = wr_color;
      case (state_q)
         IDLE: begin
            if (wr_fire) begin
               if (wr_in) mem_we = 1'b1;
               else       oob_d  = 1'b1;
            end
            // A same-edge write still lands; the clear overwrites it and its flag reset wins.
            if (clr_start) begin
               clr_col_d = clr_color;
               cnt_d     = '0;
               state_d   = CLEAR;
               busy_d    = 1'b1;
               oob_d     = 1'b0;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = clr_col_q;
            if (cnt_q == LAST_A) begin
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         clr_col_q  <= '0;
         busy_q     <= 1'b0;
         oob_q      <= 1'b0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_col_q  <= clr_col_d;
         busy_q     <= busy_d;
         oob_q      <= oob_d;
         in_range_q <= in_range_d;
      end
   end

   // Unreset dual-port RAM; the read sees the pre-write contents on a same-address collision.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_q <= mem[rd_addr];
   end

   assign color   = in_range_q ? rd_q : 12'h000;
   assign busy    = busy_q;
   assign oob_err = oob_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Randomised self-checking bench for vga_framebuffer against an array-based pixel model.
module tb_vga_framebuffer;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int SH    = 2;
   localparam int DEPTH = W * H;

   logic        clk = 1'b0;
   logic        res;
   logic [15:0] pix_x, pix_y;
   logic [11:0] color;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_x, wr_y;
   logic [11:0] wr_color;
   logic        clr_start;
   logic [11:0] clr_color;
   logic        busy;
   logic        oob_err;

   vga_framebuffer dut (
      .clk       (clk),
      .res       (res),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .color     (color),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_color  (wr_color),
      .clr_start (clr_start),
      .clr_color (clr_color),
      .busy      (busy),
      .oob_err   (oob_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   model_mem [DEPTH];
   bit   known [DEPTH];
   bit   model_oob = 1'b0;
   int   last_wx = 0, last_wy = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Expected colour of screen pixel (px,py) from the current model contents.
   function automatic int model_read(input int px, input int py, output bit valid);
      int fx = px >> SH;
      int fy = py >> SH;
      valid = 1'b1;
      if (fx >= W || fy >= H) return 0;
      valid = known[fy * W + fx];
      return model_mem[fy * W + fx];
   endfunction

   // One IDLE-state clock: expectation taken before this edge's write lands (read-old).
   task automatic tick(input string tag);
      bit valid;
      int exp_col;
      exp_col = model_read(int'(pix_x), int'(pix_y), valid);
      if (wr_valid) begin
         if (int'(wr_x) < W && int'(wr_y) < H) begin
            model_mem[int'(wr_y) * W + int'(wr_x)] = int'(wr_color);
            known[int'(wr_y) * W + int'(wr_x)]     = 1'b1;
         end else begin
            model_oob = 1'b1;
         end
      end
      if (clr_start) model_oob = 1'b0;
      @(posedge clk);
      #1;
      if (valid) check({tag, "_color"}, 32'(color), 32'(exp_col));
      check({tag, "_oob"}, 32'(oob_err), 32'(model_oob));
   endtask

   task automatic read_px(input int px, input int py, input string tag);
      pix_x = 16'(px);
      pix_y = 16'(py);
      tick(tag);
   endtask

   // Full clear, optionally with a simultaneous write; checks duration and handshake gating.
   task automatic do_clear(input logic [11:0] col, input bit with_wr, input int wx, input int wy,
                           input logic [11:0] wc);
      int n;
      int bad_ready;
      clr_start = 1'b1;
      clr_color = col;
      wr_valid  = with_wr;
      wr_x      = 16'(wx);
      wr_y      = 16'(wy);
      wr_color  = wc;
      pix_x     = 16'd640;
      pix_y     = 16'd0;
      tick("clr_start");
      clr_start = 1'b0;
      wr_valid  = 1'b0;
      clr_color = 12'h000;
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ready", 32'(wr_ready), 32'd0);
      n = 1;
      bad_ready = 0;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         #1;
         if (wr_ready === busy) bad_ready++;
         if (busy !== 1'b1) break;
         n++;
      end
      check("clr_len", 32'(n), 32'(DEPTH));
      check("clr_ready_vs_busy", 32'(bad_ready), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = int'(col);
         known[i]     = 1'b1;
      end
   endtask

   initial begin
      res = 1'b0; pix_x = '0; pix_y = '0; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
      wr_color = '0; clr_start = 1'b0; clr_color = '0;
      for (int i = 0; i < DEPTH; i++) begin model_mem[i] = 0; known[i] = 1'b0; end

      repeat (3) @(posedge clk);
      #1;
      check("rst_color", 32'(color), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_oob", 32'(oob_err), 32'd0);
      check("rst_ready", 32'(wr_ready), 32'd0);
      res = 1'b1;
      #1;
      check("ready_after_rst", 32'(wr_ready), 32'd1);

      do_clear(12'h123, 1'b0, 0, 0, 12'h000);
      read_px(0, 0, "clr_0_0");
      check("clr_0_0_val", 32'(color), 32'h123);
      read_px(400, 200, "clr_100_50");
      check("clr_100_50_val", 32'(color), 32'h123);
      read_px(639, 479, "clr_159_119");
      check("clr_159_119_val", 32'(color), 32'h123);

      wr_valid = 1'b1; wr_x = 16'd3; wr_y = 16'd2; wr_color = 12'hF0A;
      tick("wr_3_2");
      wr_valid = 1'b0;
      for (int y = 8; y < 12; y++)
         for (int x = 12; x < 16; x++) begin
            read_px(x, y, "up_3_2");
            check("up_3_2_val", 32'(color), 32'hF0A);
         end
      read_px(16, 8, "px_4_2");

      read_px(640, 0, "oor_640");
      check("oor_640_val", 32'(color), 32'h000);
      wr_valid = 1'b1; wr_x = 16'd159; wr_y = 16'd119; wr_color = 12'h0F0;
      tick("wr_corner");
      wr_valid = 1'b0;
      read_px(636, 476, "corner");
      check("corner_val", 32'(color), 32'h0F0);

      wr_valid = 1'b1; wr_x = 16'd7; wr_y = 16'd7; wr_color = 12'h555;
      pix_x = 16'd28; pix_y = 16'd28;
      tick("rdw_old");
      check("rdw_old_val", 32'(color), 32'h123);
      wr_valid = 1'b0;
      tick("rdw_new");
      check("rdw_new_val", 32'(color), 32'h555);

      for (int i = 0; i < 300; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_x     = 16'($urandom_range(0, 170));
         wr_y     = 16'($urandom_range(0, 125));
         wr_color = 12'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            pix_x = 16'((last_wx << SH) + $urandom_range(0, 3));
            pix_y = 16'((last_wy << SH) + $urandom_range(0, 3));
         end else begin
            pix_x = 16'($urandom_range(0, 700));
            pix_y = 16'($urandom_range(0, 520));
         end
         if (wr_valid) begin last_wx = int'(wr_x); last_wy = int'(wr_y); end
         check("rnd_ready", 32'(wr_ready), 32'd1);
         tick("rnd");
      end
      wr_valid = 1'b0;

      wr_valid = 1'b1; wr_x = 16'd160; wr_y = 16'd0; wr_color = 12'hFFF;
      pix_x = 16'd636; pix_y = 16'd0;
      check("oob_ready", 32'(wr_ready), 32'd1);
      tick("oob_wr");
      wr_valid = 1'b0;
      check("oob_set", 32'(oob_err), 32'd1);
      read_px(636, 0, "oob_159_0");
      read_px(0, 4, "oob_0_1");

      do_clear(12'h3C3, 1'b1, 5, 5, 12'hABC);
      check("oob_cleared", 32'(oob_err), 32'd0);
      read_px(20, 20, "clr_wr_5_5");
      check("clr_wr_5_5_val", 32'(color), 32'h3C3);

      clr_start = 1'b1; clr_color = 12'h777;
      tick("clr777_start");
      clr_start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      res = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_color", 32'(color), 32'd0);
      check("midrst_ready", 32'(wr_ready), 32'd0);
      model_oob = 1'b0;
      #2;
      res = 1'b1;
      for (int i = 0; i < 100; i++) model_mem[i] = 32'h777;
      read_px(0, 0, "midrst_a0");
      read_px(99 << SH, 0, "midrst_a99");
      check("midrst_a99_val", 32'(color), 32'h777);
      read_px(100 << SH, 0, "midrst_a100");
      check("midrst_a100_val", 32'(color), 32'h3C3);
      read_px(0, 4, "midrst_a160");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
